irqctl: RTL



---
 rtl/irqctl_pkg.sv | 40 ++++
 rtl/irqctl_sync.sv | 47 ++++
 rtl/irqctl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/irqctl_pkg.sv
// irqctl_pkg: register offsets, FSM state encoding and VECTOR field layout
// shared by the interrupt controller. Optional macro: IRQCTL_LEVEL_EN
// (adds the TRIG register at offset +4).
package irqctl_pkg;

    localparam logic [7:0] OFS_STATUS = 8'd0;
    localparam logic [7:0] OFS_MASK   = 8'd1;
    localparam logic [7:0] OFS_VECTOR = 8'd2;
    localparam logic [7:0] OFS_EOI    = 8'd3;
    localparam logic [7:0] OFS_TRIG   = 8'd4;

    // Highest mapped offset; TRIG only exists in the level-capable build.
`ifdef IRQCTL_LEVEL_EN
    localparam logic [7:0] OFS_LAST = OFS_TRIG;
`else
    localparam logic [7:0] OFS_LAST = OFS_EOI;
`endif

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    localparam int VEC_VALID_BIT = 7;
    localparam int VEC_BUSY_BIT  = 6;
    localparam int VEC_ID_MSB    = 2;
    localparam int VEC_ID_LSB    = 0;

    // Assemble a VECTOR read word from its fields.
    function automatic logic [7:0] vec_word(input logic valid, input logic busy,
                                            input logic [2:0] id);
        logic [7:0] w;
        w = 8'h00;
        w[VEC_VALID_BIT] = valid;
        w[VEC_BUSY_BIT]  = busy;
        w[VEC_ID_MSB:VEC_ID_LSB] = id;
        return w;
    endfunction

endpackage

// File: rtl/irqctl_sync.sv
// irqctl_sync: per-source 2-flop synchronizer followed by a rising-edge
// detector. A source already high when reset is released is treated as
// "already seen", so it only produces an edge after it falls and rises again.
module irqctl_sync #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    output logic [NSRC-1:0] lvl,
    output logic [NSRC-1:0] rise
);
    import irqctl_pkg::*;

    logic [NSRC-1:0] meta_q, meta_d;
    logic [NSRC-1:0] sync_q, sync_d;
    logic [NSRC-1:0] prev_q, prev_d;
    logic [1:0]      prime_q, prime_d;

    // Next-state: shift through the synchronizer; the edge history is pinned
    // high until the synchronizer holds a post-reset sample (prime_q[1]).
    always_comb begin
        meta_d  = src;
        sync_d  = meta_q;
        prime_d = {prime_q[0], 1'b1};
        prev_d  = prime_q[1] ? sync_q : '1;
    end

    // Synchronizer, edge-history and priming registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '1;
            prime_q <= 2'b00;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            prime_q <= prime_d;
        end
    end

    assign lvl  = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/irqctl.sv
// irqctl: eight-source (max) interrupt controller on the kcpsm port bus.
// Pending latch, mask, fixed lowest-index priority, VECTOR claim / EOI
// handshake. Optional macro: IRQCTL_LEVEL_EN adds per-source level mode
// through the TRIG register at BASE+4.
module irqctl
    import irqctl_pkg::*;
#(
    parameter int         NSRC = 8,
    parameter logic [7:0] BASE = 8'hF0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic [7:0]      port_id,
    input  logic [7:0]      outport,
    input  logic            write_strobe,
    input  logic            read_strobe,
    output logic [7:0]      rdata,
    output logic            sel,
    output logic            irq
);

    logic [NSRC-1:0] lvl, rise;

    irqctl_sync #(.NSRC(NSRC)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .src  (src),
        .lvl  (lvl),
        .rise (rise)
    );

    state_t          state_q, state_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [2:0]      cur_q, cur_d;
    logic            irq_q, irq_d;
    logic [NSRC-1:0] level_mode;

    logic [7:0]      ofs;
    logic [NSRC-1:0] pm, w1c, claim_clr;
    logic            any;
    logic [2:0]      win;
    logic            wr_status, wr_mask, wr_eoi, rd_vector, claim;

    // Address decode: offset wraps modulo 256 so BASE can sit anywhere.
    assign ofs       = port_id - BASE;
    assign sel       = (ofs <= OFS_LAST);
    assign wr_status = write_strobe && (ofs == OFS_STATUS);
    assign wr_mask   = write_strobe && (ofs == OFS_MASK);
    assign wr_eoi    = write_strobe && (ofs == OFS_EOI);
    assign rd_vector = read_strobe  && (ofs == OFS_VECTOR);
    assign w1c       = wr_status ? outport[NSRC-1:0] : '0;

    // Priority encoder over enabled pending sources, lowest index wins.
    always_comb begin
        pm  = pend_q & mask_q;
        any = |pm;
        win = 3'd0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (pm[k]) win = 3'(k);
        end
    end

    // A claim is only possible from IDLE and always uses the current mask.
    assign claim = rd_vector && (state_q == ST_IDLE) && any;

`ifdef IRQCTL_LEVEL_EN
    logic [NSRC-1:0] trig_q, trig_d;
    logic            wr_trig;

    assign wr_trig    = write_strobe && (ofs == OFS_TRIG);
    assign trig_d     = wr_trig ? outport[NSRC-1:0] : trig_q;
    assign level_mode = trig_q;

    // Trigger-mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) trig_q <= '0;
        else     trig_q <= trig_d;
    end
`else
    assign level_mode = '0;
`endif

    // Pending bits: a new edge is ORed in last so it beats both W1C and claim.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
        assign claim_clr[gi] = claim && (win == 3'(gi));
        assign pend_d[gi]    = level_mode[gi] ? lvl[gi]
                             : ((pend_q[gi] & ~w1c[gi] & ~claim_clr[gi]) | rise[gi]);
    end

    assign mask_d = wr_mask ? outport[NSRC-1:0] : mask_q;

    // FSM next-state and registered irq request.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        irq_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                irq_d = any;
                if (claim) begin
                    state_d = ST_SERVICE;
                    cur_d   = win;
                end
            end
            ST_SERVICE: begin
                irq_d = 1'b0;
                if (wr_eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            cur_q   <= 3'd0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            irq_q   <= irq_d;
        end
    end

    // Read mux, purely a function of port_id and current state.
    always_comb begin
        rdata = 8'h00;
        case (ofs)
            OFS_STATUS: rdata = 8'(pend_q);
            OFS_MASK:   rdata = 8'(mask_q);
            OFS_VECTOR: begin
                if (state_q == ST_SERVICE) rdata = vec_word(1'b0, 1'b1, cur_q);
                else if (any)              rdata = vec_word(1'b1, 1'b0, win);
            end
`ifdef IRQCTL_LEVEL_EN
            OFS_TRIG:   rdata = 8'(trig_q);
`endif
            default:    rdata = 8'h00;
        endcase
    end

    assign irq = irq_q;

endmodule
